bcd_display_scanner: RTL and testbench

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_disp_pkg.sv | 25 ++
 rtl/clk_prescaler.sv | 28 ++
 rtl/bcd_display_scanner.sv | 78 +++++++
 tb/tb_bcd_display_scanner.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the multiplexed BCD display blocks.
package bcd_disp_pkg;

    localparam int unsigned NUM_DIGITS      = 4;
    localparam logic [3:0]  BCD_INVALID     = 4'b1111;
    localparam int unsigned DEFAULT_CLK_DIV = 4;

    typedef logic [1:0] slot_t;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

    function automatic logic any_non_bcd(input logic [4*NUM_DIGITS-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(digits[i*4 +: 4])) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Free-running divider: count wraps 0..DIV-1, tick marks the last cycle of each period.
module clk_prescaler
    import bcd_disp_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] count;

    assign tick = (count == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes four shadowed BCD digits onto one bcd bus with a one-hot digit select,
// optional leading-zero blanking and a sticky non-BCD capture flag.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_blank,
    output logic [3:0]  bcd,
    output logic [3:0]  digit_en,
    output logic        dp_out,
    output logic        bcd_err
);

    logic [15:0] shadow_digits;
    logic [3:0]  shadow_dp;
    slot_t       idx;
    slot_t       next_idx;
    logic        tick;
    logic [3:0]  next_digit;
    logic [3:0]  zero_from;
    logic        running_zero;
    logic        blank_next;

    clk_prescaler #(
        .DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // zero_from[i] is set when digit i and every higher digit are zero
    always_comb begin
        next_idx     = idx + 2'd1;
        next_digit   = shadow_digits[{next_idx, 2'b00} +: 4];
        zero_from    = '0;
        running_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            running_zero = running_zero & (shadow_digits[(NUM_DIGITS-1-k)*4 +: 4] == 4'd0);
            zero_from[NUM_DIGITS-1-k] = running_zero;
        end
        blank_next = lz_blank && (next_idx != 2'd0) && zero_from[next_idx];
    end

    // Outputs read the shadow before this edge's load, so a coincident load shows next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            idx           <= 2'd3;
            bcd           <= '0;
            digit_en      <= '0;
            dp_out        <= 1'b0;
            bcd_err       <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
                if (any_non_bcd(digits_in)) begin
                    bcd_err <= 1'b1;
                end
            end
            if (tick) begin
                idx      <= next_idx;
                bcd      <= is_bcd(next_digit) ? next_digit : BCD_INVALID;
                digit_en <= blank_next ? 4'b0000 : (4'b0001 << next_idx);
                dp_out   <= !blank_next && shadow_dp[next_idx];
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner with CLK_DIV=4.
module tb_bcd_display_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        dp_out;
    logic        bcd_err;

    int checks = 0;
    int errors = 0;
    int slot;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_display_scanner #(
        .CLK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .bcd       (bcd),
        .digit_en  (digit_en),
        .dp_out    (dp_out),
        .bcd_err   (bcd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the downstream bcd_to_seven_seg decoder (gfedcba, active high).
    function automatic logic [6:0] seg_of(input logic [3:0] b);
        case (b)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Checks all four cycles of the current slot and leaves the bench at the next slot start.
    task automatic check_slot(input string tag, input logic [3:0] en,
                              input logic [3:0] b, input logic dp);
        for (int k = 0; k < 4; k++) begin
            chk({tag, " digit_en"}, 16'(digit_en), 16'(en));
            chk({tag, " bcd"},      16'(bcd),      16'(b));
            chk({tag, " dp_out"},   16'(dp_out),   16'(dp));
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        digits_in = d;
        dp_in     = dp;
        lz_blank  = lz;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; lz_blank = 1'b0;
        skip(2);
        chk("reset bcd",      16'(bcd),      16'h0);
        chk("reset digit_en", 16'(digit_en), 16'h0);
        chk("reset dp_out",   16'(dp_out),   16'h0);
        chk("reset bcd_err",  16'(bcd_err),  16'h0);

        // Basic scan of 1234 with dp on digit 2
        rst = 1'b0;
        do_load(16'h1234, 4'b0100, 1'b0);
        skip(2);
        chk("pre-first-tick digit_en", 16'(digit_en), 16'h0);
        skip(1);
        check_slot("scan s0", 4'b0001, 4'd4, 1'b0);
        check_slot("scan s1", 4'b0010, 4'd3, 1'b0);
        check_slot("scan s2", 4'b0100, 4'd2, 1'b1);
        check_slot("scan s3", 4'b1000, 4'd1, 1'b0);

        // Leading-zero blanking
        do_load(16'h0070, 4'b0100, 1'b1);
        skip(3);
        check_slot("lz70 s1", 4'b0010, 4'd7, 1'b0);
        check_slot("lz70 s2", 4'b0000, 4'd0, 1'b0);
        check_slot("lz70 s3", 4'b0000, 4'd0, 1'b0);
        check_slot("lz70 s0", 4'b0001, 4'd0, 1'b0);
        do_load(16'h0000, 4'b0100, 1'b1);
        skip(3);
        check_slot("lz00 s2", 4'b0000, 4'd0, 1'b0);
        check_slot("lz00 s3", 4'b0000, 4'd0, 1'b0);
        check_slot("lz00 s0", 4'b0001, 4'd0, 1'b0);
        check_slot("lz00 s1", 4'b0000, 4'd0, 1'b0);

        // Non-BCD digit capture
        do_load(16'h12A4, 4'b0000, 1'b0);
        chk("bcd_err set", 16'(bcd_err), 16'h1);
        skip(3);
        check_slot("err s3", 4'b1000, 4'd1, 1'b0);
        check_slot("err s0", 4'b0001, 4'd4, 1'b0);
        check_slot("err s1", 4'b0010, 4'hF, 1'b0);
        check_slot("err s2", 4'b0100, 4'd2, 1'b0);
        do_load(16'h1111, 4'b0000, 1'b0);
        skip(3);
        chk("bcd_err sticky", 16'(bcd_err), 16'h1);
        check_slot("1111 s0", 4'b0001, 4'd1, 1'b0);

        // Load coincident with the tick entering slot 2
        skip(3);
        digits_in = 16'h5678; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_slot("coload s2 old", 4'b0100, 4'd1, 1'b0);
        check_slot("coload s3", 4'b1000, 4'd5, 1'b0);
        check_slot("coload s0", 4'b0001, 4'd8, 1'b0);
        check_slot("coload s1", 4'b0010, 4'd7, 1'b0);
        check_slot("coload s2", 4'b0100, 4'd6, 1'b0);

        // Reset in the middle of slot 2
        check_slot("pre-rst s3", 4'b1000, 4'd5, 1'b0);
        check_slot("pre-rst s0", 4'b0001, 4'd8, 1'b0);
        check_slot("pre-rst s1", 4'b0010, 4'd7, 1'b0);
        skip(1);
        chk("pre-rst digit_en", 16'(digit_en), 16'h4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst bcd",      16'(bcd),      16'h0);
        chk("midrst digit_en", 16'(digit_en), 16'h0);
        chk("midrst dp_out",   16'(dp_out),   16'h0);
        chk("midrst bcd_err",  16'(bcd_err),  16'h0);
        rst = 1'b0;
        skip(3);
        chk("post-rst edge3 digit_en", 16'(digit_en), 16'h0);
        skip(1);
        chk("post-rst edge4 digit_en", 16'(digit_en), 16'h1);
        chk("post-rst edge4 bcd",      16'(bcd),      16'h0);

        // Chain with the segment decoder over 0000..9999
        slot = 0;
        for (int v = 0; v < 10; v++) begin
            logic [3:0] d;
            d = 4'(v);
            do_load({4{d}}, 4'b0000, 1'b0);
            skip(3);
            slot = (slot + 1) % 4;
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("seg v%0d s%0d", v, slot), 16'(seg_of(bcd)), 16'(seg_tab[v]));
                check_slot($sformatf("chain v%0d s%0d", v, slot), 4'(4'b0001 << slot), d, 1'b0);
                slot = (slot + 1) % 4;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
